password_lock_ctrl: RTL and testbench
=====================================

// Module: password_lock_ctrl
// PURPOSE
//  Parametrised keypad lock controller for the home-automation door path. Compares an entered
//  code against a stored code on each press of the enter button and drives unlock/alarm.
//  Adds over the previous checker: button edge detection, retry limit with timed lockout,
//  timed auto-relock, and in-field code change while unlocked.
// PARAMETERS
//  PW_WIDTH       17        width of entered/stored code
//  MAX_TRIES      3         consecutive wrong codes that trigger lockout (>=1)
//  LOCKOUT_CYCLES 16        cycles alarm/locked_out stay high after lockout (>=1)
//  UNLOCK_CYCLES  8         cycles unlock stays high without activity; 0 = no auto-relock
//  DEFAULT_PW     17'd45675 stored code after reset
// PORTS
//  clk           in   1                   system clock, rising edge
//  rst_n         in   1                   asynchronous active-low reset
//  in_password   in   PW_WIDTH            entered code, sampled on enter edge
//  new_password  in   PW_WIDTH            replacement code, sampled on enter edge with change_req
//  enter_btn     in   1                   enter button level (synchronous); rising edge = press
//  change_req    in   1                   level; press while UNLOCKED loads new_password
//  relock        in   1                   level; forces UNLOCKED -> LOCKED
//  unlock        out  1                   high in UNLOCKED
//  alarm         out  1                   high in LOCKOUT
//  locked_out    out  1                   high in LOCKOUT (presses ignored)
//  fail_count    out  $clog2(MAX_TRIES+1) consecutive wrong codes
//  pw_changed    out  1                   one-cycle pulse when stored code replaced
// BEHAVIOUR
//  Reset (async, rst_n=0): state=LOCKED, stored code=DEFAULT_PW, press register=0, timer=0,
//   all outputs 0. Reset mid-lockout/unlock aborts immediately; outputs drop asynchronously.
//  Press = enter_btn & ~enter_q, enter_q = enter_btn registered. Held button = one press.
//   enter_btn high when leaving reset counts as a press on first cycle.
//  unlock/alarm/locked_out decoded from state register: visible the cycle after the press.
//  LOCKED: press & in_password==stored -> UNLOCKED, fail_count<=0, timer<=UNLOCK_CYCLES-1.
//   press & mismatch: fail_count+1; if it reaches MAX_TRIES -> LOCKOUT, fail_count<=0,
//   timer<=LOCKOUT_CYCLES-1; else stay LOCKED. change_req, relock ignored.
//  UNLOCKED (priority high->low):
//   relock=1 -> LOCKED (a press the same cycle is discarded, no code change).
//   press & change_req -> stored<=new_password, pw_changed=1 next cycle, timer reloaded, stay.
//   press & ~change_req -> LOCKED (manual lock; code not compared).
//   UNLOCK_CYCLES>0 & timer==0 -> LOCKED; else timer-1. unlock high exactly UNLOCK_CYCLES
//   cycles when idle. UNLOCK_CYCLES==0: timer unused, stays UNLOCKED until relock/press.
//  LOCKOUT: presses ignored (enter_q still tracks). timer==0 -> LOCKED; else timer-1.
//   alarm/locked_out high exactly LOCKOUT_CYCLES cycles.
//  Timer width $clog2(max(LOCKOUT_CYCLES,UNLOCK_CYCLES)+1); never wraps (load, count to 0).
//  fail_count saturates at MAX_TRIES-1 in LOCKED; cleared on success or entering LOCKOUT.
//  pw_changed is 0 in every cycle except the one after a code load.
// TESTING
//  1 reset; press with 45675 -> unlock=1 next cycle, high exactly 8 cycles, then 0.
//  2 three presses with 12345 -> fail_count 1,2 then 0; alarm=locked_out=1 exactly 16 cycles.
//  3 unlock; change_req=1,new_password=78954,press -> pw_changed 1 cycle; relock; 45675 ->
//    fail_count=1; 78954 -> unlock=1.
//  4 enter_btn held high 10 cycles with wrong code -> fail_count=1 only, no lockout.
//  5 in LOCKOUT press 45675 -> ignored; rst_n=0 mid-lockout -> alarm=0 at once; after reset
//    45675 unlocks (DEFAULT_PW restored).
//  6 UNLOCKED: relock=1 and press with change_req same cycle -> LOCKED, pw_changed=0, code kept.

Source files
------------

// File: rtl/password_lock_ctrl.sv
// Keypad lock controller: compares an entered code against a stored code on
// each enter-button press and drives unlock/alarm. Includes press edge
// detection, a retry limit with timed lockout, timed auto-relock and an
// in-field code change while unlocked.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   S_LOCKED   | idle, waiting for a press; counts consecutive bad codes
//   S_UNLOCKED | door released; relock, manual lock, code change or timeout
//   S_LOCKOUT  | retry limit hit; alarm raised, presses ignored until timeout
module password_lock_ctrl #(
   parameter int                     PW_WIDTH       = 17,
   parameter int                     MAX_TRIES      = 3,
   parameter int                     LOCKOUT_CYCLES = 16,
   parameter int                     UNLOCK_CYCLES  = 8,
   parameter logic [PW_WIDTH-1:0]    DEFAULT_PW     = 17'd45675
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [PW_WIDTH-1:0]              in_password,
   input  logic [PW_WIDTH-1:0]              new_password,
   input  logic                             enter_btn,
   input  logic                             change_req,
   input  logic                             relock,
   output logic                             unlock,
   output logic                             alarm,
   output logic                             locked_out,
   output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count,
   output logic                             pw_changed
);

   localparam int FC_W    = $clog2(MAX_TRIES+1);
   localparam int TMR_MAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX+1);

   // Timer loads are "cycles - 1" so the output stays high for exactly N cycles.
   localparam logic [TMR_W-1:0] UNL_LOAD = (UNLOCK_CYCLES > 0) ? TMR_W'(UNLOCK_CYCLES-1) : '0;
   localparam logic [TMR_W-1:0] LCK_LOAD = TMR_W'(LOCKOUT_CYCLES-1);
   localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(MAX_TRIES-1);

   typedef enum logic [1:0] {
      S_LOCKED   = 2'd0,
      S_UNLOCKED = 2'd1,
      S_LOCKOUT  = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic                  enter_q;
   logic [PW_WIDTH-1:0]   stored, stored_nxt;
   logic [TMR_W-1:0]      timer, timer_nxt;
   logic [FC_W-1:0]       fail_nxt;
   logic                  pw_chg_nxt;
   logic                  press;

   // A held button yields a single press; enter_q resets low so a button held
   // through reset release is seen as a press on the first cycle.
   assign press = enter_btn & ~enter_q;

   // State register and all datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_LOCKED;
         enter_q    <= 1'b0;
         stored     <= DEFAULT_PW;
         timer      <= '0;
         fail_count <= '0;
         pw_changed <= 1'b0;
      end else begin
         state      <= state_nxt;
         enter_q    <= enter_btn;
         stored     <= stored_nxt;
         timer      <= timer_nxt;
         fail_count <= fail_nxt;
         pw_changed <= pw_chg_nxt;
      end
   end

   // Next-state, timer, retry counter and code-change logic.
   always_comb begin
      state_nxt  = state;
      stored_nxt = stored;
      timer_nxt  = timer;
      fail_nxt   = fail_count;
      pw_chg_nxt = 1'b0;

      case (state)
         S_LOCKED: begin
            if (press) begin
               if (in_password == stored) begin
                  state_nxt = S_UNLOCKED;
                  fail_nxt  = '0;
                  timer_nxt = UNL_LOAD;
               end else if (fail_count >= FC_LAST) begin
                  state_nxt = S_LOCKOUT;
                  fail_nxt  = '0;
                  timer_nxt = LCK_LOAD;
               end else begin
                  fail_nxt  = fail_count + 1'b1;
               end
            end
         end

         S_UNLOCKED: begin
            if (relock) begin
               // relock wins over a same-cycle press, including a code change
               state_nxt = S_LOCKED;
            end else if (press && change_req) begin
               stored_nxt = new_password;
               pw_chg_nxt = 1'b1;
               timer_nxt  = UNL_LOAD;
            end else if (press) begin
               state_nxt = S_LOCKED;
            end else if (UNLOCK_CYCLES > 0) begin
               if (timer == '0) state_nxt = S_LOCKED;
               else             timer_nxt = timer - 1'b1;
            end
         end

         S_LOCKOUT: begin
            if (timer == '0) state_nxt = S_LOCKED;
            else             timer_nxt = timer - 1'b1;
         end

         default: begin
            state_nxt = S_LOCKED;
         end
      endcase
   end

   // Status outputs decoded straight from the state register.
   assign unlock     = (state == S_UNLOCKED);
   assign alarm      = (state == S_LOCKOUT);
   assign locked_out = (state == S_LOCKOUT);

endmodule

// File: tb/tb_password_lock_ctrl.sv
// Directed bench for the keypad lock controller. Inputs change 1 ns after a
// rising edge; outputs are sampled at the same point.
module tb_password_lock_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [16:0] in_password;
   logic [16:0] new_password;
   logic        enter_btn;
   logic        change_req;
   logic        relock;
   logic        unlock;
   logic        alarm;
   logic        locked_out;
   logic [1:0]  fail_count;
   logic        pw_changed;

   int n_cmp = 0;
   int n_err = 0;
   int cnt;

   password_lock_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_password  (in_password),
      .new_password (new_password),
      .enter_btn    (enter_btn),
      .change_req   (change_req),
      .relock       (relock),
      .unlock       (unlock),
      .alarm        (alarm),
      .locked_out   (locked_out),
      .fail_count   (fail_count),
      .pw_changed   (pw_changed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle press with the given code; returns sampled just after the edge.
   task automatic press(input logic [16:0] code);
      in_password = code;
      enter_btn   = 1'b1;
      step();
      enter_btn   = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_password = '0; new_password = '0;
      enter_btn = 1'b0; change_req = 1'b0; relock = 1'b0;

      // 1: reset state, correct code, auto-relock after exactly 8 cycles
      repeat (3) @(posedge clk);
      #1;
      check("rst_unlock", unlock, 0);
      check("rst_alarm", alarm, 0);
      check("rst_locked_out", locked_out, 0);
      check("rst_fail", fail_count, 0);
      check("rst_pw_changed", pw_changed, 0);
      @(negedge clk) rst_n = 1'b1;
      step();
      press(17'd45675);
      check("t1_unlock", unlock, 1);
      cnt = 1;
      while (unlock && cnt < 50) begin
         step();
         if (unlock) cnt++;
      end
      check("t1_unlock_len", cnt, 8);
      check("t1_relocked", unlock, 0);

      // 2: three wrong codes -> lockout for exactly 16 cycles
      press(17'd12345);
      check("t2_fail1", fail_count, 1);
      step();
      press(17'd12345);
      check("t2_fail2", fail_count, 2);
      check("t2_no_alarm", alarm, 0);
      step();
      press(17'd12345);
      check("t2_fail_clr", fail_count, 0);
      check("t2_alarm", alarm, 1);
      check("t2_locked_out", locked_out, 1);
      cnt = 1;
      while (alarm && cnt < 50) begin
         step();
         if (alarm) cnt++;
      end
      check("t2_alarm_len", cnt, 16);
      check("t2_locked_out_end", locked_out, 0);

      // 3: code change while unlocked, old code rejected, new code accepted
      press(17'd45675);
      check("t3_unlock", unlock, 1);
      step();
      change_req = 1'b1; new_password = 17'd78954;
      press(17'd0);
      check("t3_pw_changed", pw_changed, 1);
      check("t3_still_unlocked", unlock, 1);
      change_req = 1'b0;
      step();
      check("t3_pw_changed_pulse", pw_changed, 0);
      relock = 1'b1;
      step();
      relock = 1'b0;
      check("t3_relock", unlock, 0);
      press(17'd45675);
      check("t3_old_code_fail", fail_count, 1);
      check("t3_old_code_locked", unlock, 0);
      step();
      press(17'd78954);
      check("t3_new_code_unlock", unlock, 1);
      check("t3_new_code_fail_clr", fail_count, 0);
      relock = 1'b1;
      step();
      relock = 1'b0;

      // 4: button held 10 cycles with a wrong code counts once
      in_password = 17'd12345;
      enter_btn = 1'b1;
      repeat (10) step();
      enter_btn = 1'b0;
      check("t4_held_fail", fail_count, 1);
      check("t4_held_no_alarm", alarm, 0);
      step();
      press(17'd78954);
      check("t4_unlock", unlock, 1);
      // manual lock: plain press while unlocked
      step();
      press(17'd0);
      check("t4_manual_lock", unlock, 0);
      step();

      // 5: presses ignored in lockout, reset aborts lockout and restores default
      press(17'd1); step();
      press(17'd1); step();
      press(17'd1);
      check("t5_alarm", alarm, 1);
      step();
      press(17'd78954);
      check("t5_press_ignored_unlock", unlock, 0);
      check("t5_press_ignored_alarm", alarm, 1);
      step(); step();
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_alarm", alarm, 0);
      check("t5_async_locked_out", locked_out, 0);
      @(negedge clk) rst_n = 1'b1;
      step();
      press(17'd45675);
      check("t5_default_restored", unlock, 1);
      step();

      // 6: relock beats a same-cycle change press
      relock = 1'b1; change_req = 1'b1; new_password = 17'd11111;
      press(17'd0);
      relock = 1'b0; change_req = 1'b0;
      check("t6_locked", unlock, 0);
      check("t6_no_pw_changed", pw_changed, 0);
      step();
      check("t6_no_pw_changed_late", pw_changed, 0);
      press(17'd11111);
      check("t6_new_rejected", fail_count, 1);
      step();
      press(17'd45675);
      check("t6_code_kept", unlock, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
